snail_run_detector: RTL and testbench
=====================================

Name: snail_run_detector

Overview:
- Multi-channel, parametrised "snail" run detector: each channel watches a serial bit stream D[i] and flags every run of RUN_LEN consecutive ones.
- Per channel: one SAD/HOPE/HOORAY FSM, a run counter, a registered hit output and a saturating hit counter.
- Runtime-selectable overlap mode, global enable and synchronous clear.
- Sits in the lab pattern-detection datapath as the successor of the single-channel 2-ones detector.

Parameters:
- CHANNELS, 4, number of independent detector channels (>=1)
- RUN_LEN, 2, consecutive ones needed for a hit (>=2)
- CNT_W, 8, width of each per-channel hit counter (>=1)

Ports:
- clk  input  1  clock, all state updates on posedge
- _rst  input  1  asynchronous active-low reset
- en  input  1  global enable; 0 = all state, counters and Q hold
- clr  input  1  synchronous clear of all channels; priority over en
- overlap  input  1  0 = non-overlapping runs, 1 = overlapping runs
- D  input  CHANNELS  per-channel serial data bit
- Q  output  CHANNELS  registered per-channel hit flag
- hit_cnt  output  CHANNELS*CNT_W  per-channel hit count; channel i at bits [i*CNT_W +: CNT_W]
- cnt_sat  output  CHANNELS  per-channel flag, high while hit_cnt[i] is all ones

Behaviour:
- Reset (_rst=0, async): every channel goes to SAD with run=0. Q=0, hit_cnt=0, cnt_sat=0.
- Per-channel state is derived from run (width clog2(RUN_LEN+1)):
  - SAD: run=0
  - HOPE: 0<run<RUN_LEN
  - HOORAY: run=RUN_LEN
- Next run (applied only when en=1 and clr=0):
  - D=0: run=0 from any state.
  - D=1 in SAD or HOPE: run=run+1.
  - D=1 in HOORAY, overlap=0: run=1 (HOPE). With RUN_LEN=2 this reproduces the legacy detector.
  - D=1 in HOORAY, overlap=1: stay in HOORAY.
- Q[i] is registered from state: Q[i] <= (state==HOORAY). Latency: if the RUN_LEN-th consecutive one is sampled at edge k, state is HOORAY after edge k and Q is 1 after edge k+1. Q falls one cycle after state leaves HOORAY.
- Hit counting:
  - A hit is any transition into HOORAY from SAD or HOPE, or HOORAY->HOORAY when overlap=1. Overlapping ones each count as a hit.
  - On a hit, hit_cnt[i] increments if not all ones. It saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat[i] is combinational from hit_cnt[i].
- en=0: run, state, Q and hit_cnt all hold. D is ignored.
- clr=1 (synchronous, takes effect at the edge regardless of en): run=0, Q=0, hit_cnt=0.
- overlap is sampled every enabled cycle. A change while in HOORAY affects only the next transition, with no glitch.
- Channels are fully independent. Simultaneous hits on several channels are all counted in the same cycle.
- Reset asserted mid-run immediately clears everything. After release, detection restarts from SAD; a partial run in progress is discarded.
- Illegal run value (>RUN_LEN, unreachable) recovers to SAD on the next enabled edge.

Decomposition:
- Package snail_pkg:
  - state encoding localparams SAD=0, HOPE=1, HOORAY=2 (2-bit)
  - function clog2 for run-counter width
- Sub-module snail_run_channel:
  - one channel's run counter, state decode, registered Q and saturating counter
  - instantiated CHANNELS times in a generate loop
- Top level only fans out en/clr/overlap, slices D and concatenates hit_cnt.
- A 64-bit ASCII txstate debug decode per channel is provided in simulation only.

Test Plan:
1. CHANNELS=1, RUN_LEN=2, overlap=0, D=0,1,1,1,1,0 -> Q=0,0,0,1,0,1,0 with a one-cycle lag after state; hit_cnt=2.
2. RUN_LEN=3, overlap=1, D=1 for 6 cycles then 0 -> state HOORAY from cycle 3; Q=1 from cycle 4 until one cycle after D falls; hit_cnt=4.
3. CHANNELS=2, RUN_LEN=2, D[0]=1 constant, D[1]=1,0,1,0 repeated, overlap=0, 8 cycles -> hit_cnt[0]=4, hit_cnt[1]=0, Q[1] never 1.
4. CNT_W=2, overlap=1, D=1 held for 10 cycles -> hit_cnt counts 1,2,3 then holds 3; cnt_sat=1 from the third hit on.
5. Mid-run (run=1, RUN_LEN=2) pulse en=0 for 3 cycles with D toggling, then en=1 and D=1 -> HOORAY on the first enabled edge; Q and hit_cnt frozen during en=0.
6. Assert _rst asynchronously between edges while Q=1 and hit_cnt=5 -> Q=0 and hit_cnt=0 immediately. Separately, clr=1 with en=0 -> cleared at the next edge.

Source files
------------

// File: rtl/snail_pkg.sv
// Shared definitions for the snail run detector: per-channel state encoding
// and the width helper used to size the run counter.
package snail_pkg;

    typedef enum logic [1:0] {
        SAD     = 2'd0,
        HOPE    = 2'd1,
        HOORAY  = 2'd2,
        ILLEGAL = 2'd3
    } snail_state_e;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/snail_run_channel.sv
// One detector channel: run counter with SAD/HOPE/HOORAY decode, registered
// hit flag and saturating hit counter.
module snail_run_channel
    import snail_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             en,
    input  logic             clr,
    input  logic             overlap,
    input  logic             d,
    output logic             q,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam int               RUN_W    = clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(32'd1);
    localparam logic [RUN_W-1:0] RUN_ZERO = RUN_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_MAX  = ~CNT_ZERO;

    logic [RUN_W-1:0] run_q, run_d;
    logic             q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    snail_state_e     state_s;
    logic             hit_s;

    // State is a pure decode of the run length; out-of-range values read as ILLEGAL.
    always_comb begin
        state_s = ILLEGAL;
        if (run_q == RUN_ZERO) begin
            state_s = SAD;
        end else if (run_q < RUN_MAX) begin
            state_s = HOPE;
        end else if (run_q == RUN_MAX) begin
            state_s = HOORAY;
        end else begin
            state_s = ILLEGAL;
        end
    end

    // Next run, hit flag and counter; clear beats enable, disabled cycles hold.
    always_comb begin
        run_d = run_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        hit_s = 1'b0;
        if (clr) begin
            run_d = RUN_ZERO;
            q_d   = 1'b0;
            cnt_d = CNT_ZERO;
        end else if (en) begin
            q_d = (state_s == HOORAY);
            if (!d) begin
                run_d = RUN_ZERO;
            end else begin
                case (state_s)
                    SAD, HOPE: run_d = run_q + RUN_ONE;
                    HOORAY:    run_d = overlap ? RUN_MAX : RUN_ONE;
                    default:   run_d = RUN_ZERO;
                endcase
            end
            // Non-overlapping HOORAY restarts at 1 (< RUN_MAX), so landing on RUN_MAX is a hit.
            hit_s = (run_d == RUN_MAX);
            if (hit_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            run_d = run_q;
            q_d   = q_q;
            cnt_d = cnt_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            run_q <= RUN_ZERO;
            q_q   <= 1'b0;
            cnt_q <= CNT_ZERO;
        end else begin
            run_q <= run_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q       = q_q;
    assign hit_cnt = cnt_q;
    assign cnt_sat = &cnt_q;

`ifndef SYNTHESIS
    logic [63:0] txstate;

    // ASCII state name for waveform viewing.
    always_comb begin
        case (state_s)
            SAD:     txstate = "SAD     ";
            HOPE:    txstate = "HOPE    ";
            HOORAY:  txstate = "HOORAY  ";
            default: txstate = "ILLEGAL ";
        endcase
    end
`endif

endmodule

// File: rtl/snail_run_detector.sv
// Multi-channel run detector: fans shared controls out to independent
// channels and packs their hit counters side by side.
module snail_run_detector
    import snail_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int RUN_LEN  = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      _rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      overlap,
    input  logic [CHANNELS-1:0]       D,
    output logic [CHANNELS-1:0]       Q,
    output logic [CHANNELS*CNT_W-1:0] hit_cnt,
    output logic [CHANNELS-1:0]       cnt_sat
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        snail_run_channel #(
            .RUN_LEN(RUN_LEN),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk    (clk),
            ._rst   (_rst),
            .en     (en),
            .clr    (clr),
            .overlap(overlap),
            .d      (D[i]),
            .q      (Q[i]),
            .hit_cnt(hit_cnt[i*CNT_W +: CNT_W]),
            .cnt_sat(cnt_sat[i])
        );
    end

endmodule

// File: tb/tb_snail_run_detector.sv
// Scoreboard bench: a streak-length reference model predicts Q/hit_cnt/cnt_sat
// for every clock edge; a monitor compares on the falling edge.
module tb_snail_run_detector;

    localparam int CH  = 4;
    localparam int RL  = 3;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic               clk;
    logic               _rst;
    logic               en;
    logic               clr;
    logic               overlap;
    logic [CH-1:0]      D;
    logic [CH-1:0]      Q;
    logic [CH*CW-1:0]   hit_cnt;
    logic [CH-1:0]      cnt_sat;

    snail_run_detector #(.CHANNELS(CH), .RUN_LEN(RL), .CNT_W(CW)) dut (
        .clk    (clk),
        ._rst   (_rst),
        .en     (en),
        .clr    (clr),
        .overlap(overlap),
        .D      (D),
        .Q      (Q),
        .hit_cnt(hit_cnt),
        .cnt_sat(cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0]    q;
        logic [CH*CW-1:0] cnt;
        logic [CH-1:0]    sat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: length of the current streak of ones since the last restart.
    int   streak [CH];
    bit   mq     [CH];
    int   mcnt   [CH];

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            streak[c] = 0;
            mq[c]     = 1'b0;
            mcnt[c]   = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit c_in, input bit ov, input logic [CH-1:0] d);
        bit hooray;
        exp_t x;
        for (int c = 0; c < CH; c++) begin
            if (c_in) begin
                streak[c] = 0;
                mq[c]     = 1'b0;
                mcnt[c]   = 0;
            end else if (e) begin
                hooray = (streak[c] >= RL);
                mq[c]  = hooray;
                if (d[c]) begin
                    if (hooray && !ov) streak[c] = 1;
                    else               streak[c] = streak[c] + 1;
                    if ((streak[c] >= RL) && (!hooray || ov) && (mcnt[c] < MAX))
                        mcnt[c] = mcnt[c] + 1;
                end else begin
                    streak[c] = 0;
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            x.q[c]           = mq[c];
            x.cnt[c*CW +: CW] = mcnt[c][CW-1:0];
            x.sat[c]         = (mcnt[c] == MAX);
        end
        exp_q.push_back(x);
    endtask

    task automatic drive(input bit e, input bit c_in, input bit ov, input logic [CH-1:0] d);
        en      = e;
        clr     = c_in;
        overlap = ov;
        D       = d;
        @(posedge clk);
        model_step(e, c_in, ov, d);
        #1;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (Q !== '0 || hit_cnt !== '0 || cnt_sat !== '0) begin
            bad++;
            $display("FAIL %s: Q=%b hit_cnt=%h cnt_sat=%b, want all zero", name, Q, hit_cnt, cnt_sat);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (Q !== e.q) begin
                    bad++;
                    $display("FAIL q @%0t: got %b want %b", $time, Q, e.q);
                end
                total++;
                if (hit_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL hit_cnt @%0t: got %h want %h", $time, hit_cnt, e.cnt);
                end
                total++;
                if (cnt_sat !== e.sat) begin
                    bad++;
                    $display("FAIL cnt_sat @%0t: got %b want %b", $time, cnt_sat, e.sat);
                end
            end
        end
    end

    initial begin
        logic [63:0] sad_str;
        bit          ov_r;
        sad_str = "SAD     ";
        _rst    = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        overlap = 1'b0;
        D       = '0;
        model_clear();
        #12;
        check_zero("reset_state");
        total++;
        if (dut.g_ch[0].u_ch.txstate !== sad_str) begin
            bad++;
            $display("FAIL txstate_reset: got %h want %h", dut.g_ch[0].u_ch.txstate, sad_str);
        end
        @(negedge clk);
        _rst = 1'b1;

        // Non-overlapping runs on ch0, overlapping-off alternating pattern on ch1.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, {1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1});
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 4'b0000);

        // Overlapping all-ones streak, then async reset mid-run with Q high.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 4'b1111);
        @(negedge clk);
        #2 _rst = 1'b0;
        #1 check_zero("async_reset");
        model_clear();
        @(posedge clk);
        #1 _rst = 1'b1;

        // Partial run frozen by en=0 while D toggles, then completes.
        drive(1'b1, 1'b0, 1'b0, 4'b1111);
        drive(1'b1, 1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 1'b0, 4'b0101);
        drive(1'b1, 1'b0, 1'b0, 4'b1111);
        drive(1'b1, 1'b0, 1'b0, 4'b1111);
        drive(1'b1, 1'b0, 1'b0, 4'b0000);

        // Clear while disabled.
        drive(1'b0, 1'b1, 1'b0, 4'b1111);
        drive(1'b1, 1'b0, 1'b0, 4'b0000);

        // Saturation under overlap, overlap dropped mid-HOORAY.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b1, 4'b1011);
        for (int i = 0; i < 6; i++)  drive(1'b1, 1'b0, 1'b0, 4'b1011);
        drive(1'b1, 1'b1, 1'b0, 4'b1111);

        // Randomized traffic.
        ov_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic [CH-1:0] d_r;
            for (int c = 0; c < CH; c++) d_r[c] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) ov_r = ~ov_r;
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 59) == 0), ov_r, d_r);
        end

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
